// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory and its program loader.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam logic [31:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/inst_mem_loader.sv
// Program-load sequencer: walks ptr from load_base for load_len accepted beats.
// With INST_MEM_BOUNDS_CHK_EN defined, loads running past the top are rejected via load_err.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              busy,
    output logic              load_done,
`ifdef INST_MEM_BOUNDS_CHK_EN
    output logic              load_err,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   eff_len;
    logic              zdone_q, zdone_d;
`ifdef INST_MEM_BOUNDS_CHK_EN
    logic              err_q, err_d;
    logic [ADDR_W+1:0] span;
    logic              out_of_range;

    assign span         = {2'b00, load_base} + {1'b0, eff_len};
    assign out_of_range = span > {1'b0, DEPTH};
`endif

    // Oversized requests saturate at the full array.
    assign eff_len = (load_len > DEPTH) ? DEPTH : load_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            zdone_q <= 1'b0;
`ifdef INST_MEM_BOUNDS_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            zdone_q <= zdone_d;
`ifdef INST_MEM_BOUNDS_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        zdone_d = 1'b0;
`ifdef INST_MEM_BOUNDS_CHK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (eff_len == '0) begin
                        zdone_d = 1'b1;
`ifdef INST_MEM_BOUNDS_CHK_EN
                    end else if (out_of_range) begin
                        err_d = 1'b1;
`endif
                    end else begin
                        state_d = LOAD;
                        ptr_d   = load_base;
                        rem_d   = eff_len;
                    end
                end
            end
            LOAD: begin
                if (load_valid) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_ready = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign load_done  = (state_q == DONE) || zdone_q;
`ifdef INST_MEM_BOUNDS_CHK_EN
    assign load_err   = err_q;
`endif
    assign wr_en      = (state_q == LOAD) && load_valid;
    assign wr_addr    = ptr_q;
    assign wr_data    = load_data;

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with registered fetch port and a streaming program loader.
// Optional feature macro: INST_MEM_BOUNDS_CHK_EN (adds load_err, rejects wrapping loads).
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              busy,
`ifdef INST_MEM_BOUNDS_CHK_EN
    output logic              load_err,
`endif
    output logic              load_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    inst_mem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .busy       (busy),
        .load_done  (load_done),
`ifdef INST_MEM_BOUNDS_CHK_EN
        .load_err   (load_err),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // No reset on the array: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
        end else if (flush || busy) begin
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
        end else if (fetch_en) begin
            inst       <= mem[fetch_addr];
            inst_valid <= 1'b1;
        end
    end

endmodule
